// File: rtl/mem_pkg.sv
// Shared types and width helpers for the memory responder and its cache.
// Default widths describe the 14-bit address, 16-bit data, 16-line configuration.
package mem_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LINES  = 16;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(lines);
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_LINES);
    localparam int DEF_TAG_W = tag_w(DEF_ADDR_W, DEF_LINES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RAM_RD,
        ST_FILL,
        ST_WRITE,
        ST_RESP
    } mem_state_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] data;
    } line_t;

endpackage

// File: rtl/cache_array.sv
// Direct-mapped one-word-per-line storage: synchronous write, combinational read.
// Valid bits clear asynchronously on reset; tag and data arrays are not reset.
module cache_array #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data
);
    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx]  <= wr_tag;
            data_q[idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder with an optional write-through, write-allocate word cache
// (cache built only when MEM_RESPONDER_CACHE_EN is defined); one request in flight at a time.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int LINES      = 16,
    parameter int RAM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_hit,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    if (LINES < 2 || (LINES & (LINES - 1)) != 0 || RAM_LAT < 1) begin : g_param_check
        $error("mem_responder: LINES must be a power of two >= 2 and RAM_LAT >= 1");
    end

    mem_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]      lat_cnt;
    logic                  hit;
    logic [DATA_WIDTH-1:0] line_data;

`ifdef MEM_RESPONDER_CACHE_EN
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_WIDTH, LINES);

    logic                  line_vld;
    logic [TAG_W-1:0]      line_tag;
    logic                  line_wr;
    logic [DATA_WIDTH-1:0] line_wdata;

    // Fills take the RAM word; stores allocate with the captured store data.
    assign line_wr    = (state == ST_FILL) || (state == ST_WRITE);
    assign line_wdata = (state == ST_FILL) ? ram_rdata : wdata_q;

    cache_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_WIDTH)
    ) u_cache (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (line_wr),
        .idx      (addr_q[IDX_W-1:0]),
        .wr_tag   (addr_q[ADDR_WIDTH-1:IDX_W]),
        .wr_data  (line_wdata),
        .rd_valid (line_vld),
        .rd_tag   (line_tag),
        .rd_data  (line_data)
    );

    assign hit = line_vld && (line_tag == addr_q[ADDR_WIDTH-1:IDX_W]);
`else
    assign hit       = 1'b0;
    assign line_data = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_cnt   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_hit   <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_we) begin
                            state     <= ST_WRITE;
                            ram_cs    <= 1'b1;
                            ram_we    <= 1'b1;
                            ram_addr  <= req_addr;
                            ram_wdata <= req_wdata;
                        end else begin
                            state <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b1;
                        rsp_rdata <= line_data;
                    end else begin
                        state    <= ST_RAM_RD;
                        ram_cs   <= 1'b1;
                        ram_oe   <= 1'b1;
                        ram_addr <= addr_q;
                        lat_cnt  <= '0;
                    end
                end
                ST_RAM_RD: begin
                    if (lat_cnt == CNT_W'(RAM_LAT - 1)) begin
                        state    <= ST_FILL;
                        ram_cs   <= 1'b0;
                        ram_oe   <= 1'b0;
                        ram_addr <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_FILL: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_hit   <= 1'b0;
                    rsp_rdata <= ram_rdata;
                end
                ST_WRITE: begin
                    state     <= ST_RESP;
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_addr  <= '0;
                    ram_wdata <= '0;
                    rsp_valid <= 1'b1;
                    rsp_hit   <= 1'b0;
                    rsp_rdata <= wdata_q;
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_hit   <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the accumulator CPU's fetch, load and store requests. It sits between the CPU datapath and `single_port_sync_ram_large`, and fronts the RAM with a direct-mapped, write-through, write-allocate word cache. It returns a one-cycle response pulse for every accepted request, and reports whether that request hit the cache.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: word address width; matches the RAM.
- `DATA_WIDTH`, 16: word width.
- `LINES`, 16: number of cache lines, one word per line. Must be a power of two and at least 2.
- `RAM_LAT`, 1: RAM read latency in cycles, at least 1.

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  CPU request strobe.
- `req_ready`  out  1  responder is idle and can accept a request.
- `req_we`  in  1  1 = store, 0 = fetch or load.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  store data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  DATA_WIDTH  read data; for a store, echoes the stored data.
- `rsp_hit`  out  1  request was served from the cache; always 0 for stores.
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each  RAM controls.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_wdata`  out  DATA_WIDTH  RAM write data. The tristate drive onto the RAM's bidirectional data bus is done in the wrapper, not in this block.
- `ram_rdata`  in  DATA_WIDTH  RAM read data.

## Operation
- A request is accepted on a rising edge where `req_valid && req_ready`. The address, write enable and write data are captured into registers at acceptance.
- Only one request is outstanding at a time. `req_ready` is 1 only in IDLE.
- Address split:
  - index = `req_addr[IDX_W-1:0]`, where `IDX_W = $clog2(LINES)`.
  - tag = `req_addr[ADDR_WIDTH-1:IDX_W]`.
  - Each line holds a valid bit, a tag and a data word.
- FSM states are IDLE, LOOKUP, RAM_RD, FILL, WRITE and RESP. Transitions:
  - IDLE → LOOKUP when a read is accepted.
  - IDLE → WRITE when a store is accepted.
  - LOOKUP → RESP on a hit, with `rsp_hit` = 1.
  - LOOKUP → RAM_RD on a miss.
  - RAM_RD drives `ram_cs` = 1, `ram_oe` = 1 and `ram_addr` = the captured address for RAM_LAT cycles, then → FILL.
  - FILL samples `ram_rdata`, writes the line (valid = 1, new tag, data) and moves to RESP with `rsp_hit` = 0. A valid line with a different tag is replaced without notice.
  - WRITE drives `ram_cs` = 1, `ram_we` = 1 and `ram_wdata` for one cycle. In the same cycle it writes the line (valid = 1, tag, data), which is the write-allocate behaviour, then → RESP.
  - RESP asserts `rsp_valid` for one cycle, then → IDLE.
- Responses are not backpressured. The CPU must sample `rsp_rdata` and `rsp_hit` while `rsp_valid` = 1.
- No read ever returns stale data, because the cache and RAM are updated in the same cycle on every store.

## Timing
- Acceptance edge = cycle 0.
- Read hit: `rsp_valid` is high in cycle 2.
- Read miss: `rsp_valid` is high in cycle 3 + RAM_LAT, i.e. cycle 4 with the default RAM_LAT.
- Store: `rsp_valid` is high in cycle 2. RAM `we` is high in cycle 1.
- `req_ready` rises in the cycle after RESP. Back-to-back requests therefore start at best every 3 cycles.
- RAM controls are 0 outside RAM_RD and WRITE. `ram_we` and `ram_oe` are never high in the same cycle.
- Reset, asynchronous:
  - FSM goes to IDLE and every valid bit clears.
  - `req_ready` = 1.
  - `rsp_valid`, `rsp_hit`, `rsp_rdata`, `ram_cs`, `ram_we`, `ram_oe`, `ram_addr` and `ram_wdata` = 0.
  - Tag and data arrays need not be cleared.
- Reset during RAM_RD, FILL or WRITE aborts the request. No response is issued and no line is written after reset asserts. A store interrupted during WRITE may or may not have reached RAM.
- Hit test: `valid[index] && tag[index] == captured tag`. Address 0 and the all-ones address behave like any other address.

## Configuration
- `MEM_RESPONDER_CACHE_EN` defined:
  - The cache is present and behaves as described above.
- `MEM_RESPONDER_CACHE_EN` undefined:
  - The cache arrays are not built. LOOKUP always goes to RAM_RD.
  - FILL only latches the read data.
  - WRITE writes RAM only.
  - `rsp_hit` is tied to 0.
  - Every read takes 3 + RAM_LAT cycles.

## Structure
- Package `mem_pkg` holds:
  - the FSM state enum `mem_state_t`;
  - the `line_t` struct (valid, tag, data), parameterised through package localparams for the default widths;
  - `IDX_W` and `TAG_W` as helper functions.
- The natural sub-module is `cache_array`: a synchronous-write, combinational-read tag/data/valid storage with an asynchronous valid clear. The responder FSM instantiates it only when `MEM_RESPONDER_CACHE_EN` is defined.

## Test plan
All cases use the default parameters.
- **Cold read:** preload RAM[0x10D] = 0x0007, reset, read 0x10D.
  - Required: `rsp_valid` in cycle 4 with `rsp_rdata` = 0x0007 and `rsp_hit` = 0.
  - Repeating the read gives a response in cycle 2 with `rsp_hit` = 1.
- **Store then read:** store 0x1234 to 0x10E.
  - Required: RAM `we` pulse in cycle 1 and `rsp_valid` in cycle 2.
  - A following read of 0x10E returns 0x1234 with `rsp_hit` = 1.
  - RAM[0x10E] = 0x1234.
- **Conflict:** read 0x100, read 0x110 (same index, different tag), read 0x100 again.
  - Required: all three miss and return the current RAM contents.
- **Reset mid-miss:** assert `rst` during RAM_RD.
  - Required: no `rsp_valid` follows, `req_ready` = 1 immediately, and a subsequent read of the same address misses.
- **Protocol rule:** hold `req_valid` = 1 with new addresses during a miss.
  - Required: no second acceptance until `req_ready` rises, and responses come back in request order.
- **Cache compiled out:** build without `MEM_RESPONDER_CACHE_EN` and read 0x10D twice.
  - Required: both reads respond in cycle 4 with `rsp_hit` = 0.
